button_debounce: RTL and testbench
==================================

// Module: button_debounce
//
// PURPOSE
// - Input-side counterpart to the LED blinker: debounces one raw pushbutton pin and produces
//   a clean level and single-cycle press/release event pulses.
// - Sits between a board button pad (Upduino GPIO) and user logic.
// - Tested from the simulation top with a small CBITS, in the same way as the blinker.
//
// PARAMETERS
// - CBITS        default 16   stability counter width; input must be stable for 2^CBITS clocks
// - SYNC_STAGES  default 2    metastability synchronizer depth; minimum 2
// - LBITS        default 22   long-press counter width; used only with BUTTON_LONGPRESS_EN
//
// PORTS
// - i_clk     input   1  system clock
// - i_rst_n   input   1  asynchronous, active-low reset
// - i_btn     input   1  raw button pin, active-high, asynchronous to i_clk
// - o_level   output  1  debounced button level; 1 = held
// - o_press   output  1  one-cycle pulse on a debounced 0->1 transition
// - o_release output  1  one-cycle pulse on a debounced 1->0 transition
// - o_long    output  1  one-cycle pulse on a long press (see CONFIGURATION)
//
// BEHAVIOUR
// - Reset: all outputs are 0. The synchronizer flops and the counters are cleared to 0.
//   State is IDLE. Reset is asynchronous: asserting it mid-count aborts the count with no pulse.
// - Synchronizer: i_btn passes through SYNC_STAGES flops; the last stage is btn_s.
//   The FSM looks only at btn_s.
// - FSM states:
//   - IDLE -> PRESS_WAIT when btn_s=1; cnt<=0.
//   - PRESS_WAIT:
//     - btn_s=0 -> IDLE. Glitch rejected, no pulse.
//     - Otherwise cnt++.
//     - When cnt == 2^CBITS-1 and btn_s=1 -> HELD; o_press=1 for that one cycle; o_level<=1.
//   - HELD -> RELEASE_WAIT when btn_s=0; cnt<=0.
//   - RELEASE_WAIT is symmetric with PRESS_WAIT:
//     - btn_s=1 -> HELD, no pulse.
//     - At terminal count -> IDLE; o_release=1; o_level<=0.
// - Latency: from the first i_btn=1 sample edge to o_press high is SYNC_STAGES + 2^CBITS + 1
//   clocks (19 for CBITS=4, SYNC_STAGES=2). Release latency is identical.
// - o_press and o_release are never high in the same cycle.
// - Each event pulse lasts exactly 1 cycle.
// - o_level changes in the same cycle as its pulse.
// - cnt is CBITS wide. It never wraps, because it is reloaded on every state entry.
// - Input toggling faster than 2^CBITS clocks never changes o_level.
//
// CONFIGURATION
// - Macro BUTTON_LONGPRESS_EN.
// - Defined:
//   - An LBITS-wide lcnt clears on entry to HELD and increments each cycle in HELD.
//   - lcnt saturates at 2^LBITS-1 and does not wrap.
//   - o_long pulses for 1 cycle when lcnt first reaches 2^LBITS-1. This gives at most one
//     o_long per hold.
//   - lcnt freezes in RELEASE_WAIT and resumes if the FSM bounces back to HELD.
// - Not defined: o_long is tied to 0 and lcnt is not instantiated. The port list is unchanged.
//
// TESTING (CBITS=4, SYNC_STAGES=2, LBITS=5, clk period 10)
// - Reset, then i_btn=0 for 100 clocks -> all outputs stay 0.
// - 10-clock i_btn=1 glitch -> no o_press, o_level stays 0, FSM returns to IDLE.
// - i_btn=1 held for 40 clocks -> o_press high for exactly 1 cycle at clock 19;
//   o_level=1 from then on.
// - Then i_btn=0 -> o_release pulse 19 clocks later; o_level=0.
//   A 5-clock 0-bounce while HELD produces no pulse.
// - i_rst_n driven low at clock 10 of a press -> outputs are 0 at once.
//   After release of reset with i_btn still 1 -> o_press appears 19 clocks later.
// - With BUTTON_LONGPRESS_EN, a 100-clock hold -> exactly one o_long, 31 clocks after o_press.
//   Without the macro -> o_long stays 0.

Source files
------------

// File: rtl/button_debounce.sv
// Pushbutton debouncer: synchronizer, stability-count FSM, registered level and press/release pulses.
// Optional long-press pulse on o_long when BUTTON_LONGPRESS_EN is defined; otherwise o_long is 0.
module button_debounce #(
   parameter int CBITS       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int LBITS       = 22
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long
);

   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

   localparam logic [CBITS-1:0] CNT_MAX = '1;

   state_t                 state;
   logic [CBITS-1:0]       cnt;
   logic [SYNC_STAGES-1:0] sync;
   logic                   btn_s;

   assign btn_s = sync[SYNC_STAGES-1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) sync <= '0;
      else          sync <= {sync[SYNC_STAGES-2:0], i_btn};
   end

   // cnt is reloaded on every wait-state entry, so it never wraps
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         o_level   <= 1'b0;
         o_press   <= 1'b0;
         o_release <= 1'b0;
      end else begin
         o_press   <= 1'b0;
         o_release <= 1'b0;
         case (state)
            IDLE: begin
               if (btn_s) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!btn_s) begin
                  state <= IDLE;
               end else if (cnt == CNT_MAX) begin
                  state   <= HELD;
                  o_press <= 1'b1;
                  o_level <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HELD: begin
               if (!btn_s) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (btn_s) begin
                  state <= HELD;
               end else if (cnt == CNT_MAX) begin
                  state     <= IDLE;
                  o_release <= 1'b1;
                  o_level   <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BUTTON_LONGPRESS_EN
   localparam logic [LBITS-1:0] LCNT_MAX = '1;

   logic [LBITS-1:0] lcnt;
   logic             press_done;

   assign press_done = (state == PRESS_WAIT) && btn_s && (cnt == CNT_MAX);

   // Cleared only on a fresh press; a bounce back from RELEASE_WAIT resumes the count
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lcnt   <= '0;
         o_long <= 1'b0;
      end else begin
         o_long <= 1'b0;
         if (press_done) begin
            lcnt <= '0;
         end else if (state == HELD && lcnt != LCNT_MAX) begin
            lcnt   <= lcnt + 1'b1;
            o_long <= (lcnt == LCNT_MAX - 1'b1);
         end
      end
   end
`else
   // LBITS only matters for the long-press counter; reference it so the port list stays uniform
   assign o_long = (LBITS < 0);
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Randomized and directed bench for button_debounce against a run-length reference model.
// Honors BUTTON_LONGPRESS_EN the same way as the design.
module tb_button_debounce;

   localparam int CBITS = 4;
   localparam int SYNC  = 2;
   localparam int LBITS = 5;
   localparam int STABLE_RUN = (1 << CBITS) + 1;
   localparam int LMAX = (1 << LBITS) - 1;

   logic i_clk = 1'b0;
   logic i_rst_n = 1'b0;
   logic i_btn = 1'b0;
   logic o_level, o_press, o_release, o_long;

   button_debounce #(.CBITS(CBITS), .SYNC_STAGES(SYNC), .LBITS(LBITS)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn),
      .o_level(o_level), .o_press(o_press), .o_release(o_release), .o_long(o_long)
   );

   always #5 i_clk = ~i_clk;

   int n_chk = 0, n_pass = 0;
   int cyc = 0;
   int n_press = 0, n_rel = 0, n_long = 0;
   int press_cyc = 0, rel_cyc = 0, long_cyc = 0;

   // Reference: level flips once btn_s has disagreed with it on STABLE_RUN consecutive edges
   logic [SYNC-1:0] m_sync;
   int   m_run, m_lc;
   logic m_lev, m_press, m_rel, m_long;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic model_reset();
      m_sync = '0; m_run = 0; m_lc = 0;
      m_lev = 0; m_press = 0; m_rel = 0; m_long = 0;
   endtask

   task automatic model_edge();
      logic bs, held;
      bs   = m_sync[SYNC-1];
      held = m_lev && (m_run == 0);
      m_sync = {m_sync[SYNC-2:0], i_btn};
      m_press = 0; m_rel = 0; m_long = 0;
`ifdef BUTTON_LONGPRESS_EN
      if (held && m_lc < LMAX) begin
         m_lc++;
         if (m_lc == LMAX) m_long = 1;
      end
`else
      if (held) m_lc = 0;
`endif
      if (bs != m_lev) begin
         m_run++;
         if (m_run == STABLE_RUN) begin
            m_lev = bs; m_run = 0; m_lc = 0;
            if (bs) m_press = 1; else m_rel = 1;
         end
      end else begin
         m_run = 0;
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      cyc++;
      if (i_rst_n) model_edge();
      #1;
      chk("outs", {28'd0, o_long, o_level, o_press, o_release},
                  {28'd0, m_long, m_lev, m_press, m_rel});
      if (o_press)   begin n_press++; press_cyc = cyc; end
      if (o_release) begin n_rel++;   rel_cyc   = cyc; end
      if (o_long)    begin n_long++;  long_cyc  = cyc; end
   endtask

   task automatic run(input logic v, input int n);
      i_btn = v;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int t0, p0, r0, l0;
      model_reset();
      #1;
      chk("reset_outs", {o_long, o_level, o_press, o_release}, 4'b0000);
      repeat (3) step();
      i_rst_n = 1'b1;

      // Quiet line
      run(1'b0, 100);
      chk("idle_press", n_press, 0);

      // Short glitch is rejected
      run(1'b1, 10);
      run(1'b0, 30);
      chk("glitch_press", n_press, 0);
      chk("glitch_level", o_level, 1'b0);

      // Clean press: pulse on clock 19
      t0 = cyc; p0 = n_press;
      run(1'b1, 40);
      chk("press_cnt", n_press - p0, 1);
      chk("press_lat", press_cyc - t0, 19);
      chk("press_level", o_level, 1'b1);

      // Clean release
      t0 = cyc; r0 = n_rel;
      run(1'b0, 40);
      chk("rel_cnt", n_rel - r0, 1);
      chk("rel_lat", rel_cyc - t0, 19);
      chk("rel_level", o_level, 1'b0);

      // Bounce while held
      run(1'b1, 30);
      r0 = n_rel;
      run(1'b0, 5);
      run(1'b1, 30);
      chk("bounce_rel", n_rel - r0, 0);
      chk("bounce_level", o_level, 1'b1);
      run(1'b0, 40);

      // Reset in the middle of a press
      p0 = n_press;
      run(1'b1, 10);
      i_rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_async", {o_long, o_level, o_press, o_release}, 4'b0000);
      repeat (4) step();
      i_rst_n = 1'b1;
      t0 = cyc;
      run(1'b1, 30);
      chk("rst_press_cnt", n_press - p0, 1);
      chk("rst_press_lat", press_cyc - t0, 19);
      run(1'b0, 40);

      // Long hold
      l0 = n_long;
      t0 = cyc;
      run(1'b1, 100);
`ifdef BUTTON_LONGPRESS_EN
      chk("long_cnt", n_long - l0, 1);
      chk("long_ofs", long_cyc - press_cyc, 31);
`else
      chk("long_cnt", n_long - l0, 0);
`endif
      chk("long_press_lat", press_cyc - t0, 19);
      run(1'b0, 40);

      // Random bursts of mixed lengths against the model
      for (int b = 0; b < 150; b++) begin
         int len;
         len = (b % 3 == 0) ? $urandom_range(20, 60) : $urandom_range(1, 20);
         run(logic'($urandom_range(0, 1)), len);
      end
      chk("rand_events", (n_press >= n_rel) && (n_press - n_rel <= 1), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
